// File: rtl/mux4_rr_arbiter_pkg.sv
// ============================================================================
// mux_arb_pkg : shared constants, FSM state type and round-robin helpers. Rev 1.0
// ============================================================================
`default_nettype none

package mux_arb_pkg;

  localparam int NUM_REQ = 4;
  localparam int SEL_W   = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // Winner is the first set bit after 'last', wrapping 3 -> 0; returns 'last' if none.
  function automatic logic [SEL_W-1:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                               input logic [SEL_W-1:0]   last);
    logic [SEL_W-1:0] idx;
    logic             found;
    rr_pick = last;
    found   = 1'b0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = last + SEL_W'(i);
      if (!found && req[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

  function automatic logic [NUM_REQ-1:0] onehot(input logic [SEL_W-1:0] idx);
    onehot = NUM_REQ'(1) << idx;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mux4_rr_arbiter_if.sv
// ============================================================================
// mux4_rr_arbiter_if : requester/arbiter bus; MUX_ARB_LOCK_EN adds lock. Rev 1.0
// ============================================================================
`default_nettype none

interface mux4_rr_arbiter_if #(
  parameter int DW = 1
);
  import mux_arb_pkg::*;

  logic [NUM_REQ-1:0] req;
  logic [DW-1:0]      din0;
  logic [DW-1:0]      din1;
  logic [DW-1:0]      din2;
  logic [DW-1:0]      din3;
  logic [NUM_REQ-1:0] gnt;
  logic               s1;
  logic               s0;
  logic [DW-1:0]      dout;
  logic               valid;
`ifdef MUX_ARB_LOCK_EN
  logic               lock;
`endif

  modport master (
`ifdef MUX_ARB_LOCK_EN
    output lock,
`endif
    output req, din0, din1, din2, din3,
    input  gnt, s1, s0, dout, valid
  );

  modport slave (
`ifdef MUX_ARB_LOCK_EN
    input  lock,
`endif
    input  req, din0, din1, din2, din3,
    output gnt, s1, s0, dout, valid
  );

endinterface

`default_nettype wire

// File: rtl/mux4_rr_arbiter_mux_4_1.sv
// ============================================================================
// mux_4_1 : single-bit 4:1 mux cell selected by {s1,s0}. Rev 1.0
// ============================================================================
`default_nettype none

module mux_4_1 (
  input  logic i0,
  input  logic i1,
  input  logic i2,
  input  logic i3,
  input  logic s1,
  input  logic s0,
  output logic out
);

  assign out = s1 ? (s0 ? i3 : i2) : (s0 ? i1 : i0);

endmodule

`default_nettype wire

// File: rtl/mux4_rr_arbiter.sv
// ============================================================================
// mux4_rr_arbiter : round-robin owner of a shared 4:1 mux with bounded hold.
// Define MUX_ARB_LOCK_EN to add a lock input that suppresses hold expiry. Rev 1.0
// ============================================================================
`default_nettype none

module mux4_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int DW       = 1,
  parameter int HOLD_MAX = 4
) (
  input  logic               clk,
  input  logic               rst,
  mux4_rr_arbiter_if.slave   bus
);

  localparam int               CNT_W   = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(HOLD_MAX - 1);

  state_t             state, state_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic [SEL_W-1:0]   last, last_n;
  logic [NUM_REQ-1:0] gnt_r, gnt_n;
  logic [SEL_W-1:0]   sel_r, sel_n;
  logic               valid_r, valid_n;
  logic [NUM_REQ-1:0] others;
  logic               take;
  logic [SEL_W-1:0]   take_idx;
  logic               hold_lock;
  logic [DW-1:0]      dout_w;

`ifdef MUX_ARB_LOCK_EN
  assign hold_lock = bus.lock;
`else
  assign hold_lock = 1'b0;
`endif

  // In GRANT, 'last' is the current owner, so masking it yields the competitors.
  assign others = bus.req & ~onehot(last);

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    last_n   = last;
    gnt_n    = gnt_r;
    sel_n    = sel_r;
    valid_n  = valid_r;
    take     = 1'b0;
    take_idx = last;

    case (state)
      IDLE: begin
        if (|bus.req) begin
          take     = 1'b1;
          take_idx = rr_pick(bus.req, last);
        end
      end
      GRANT: begin
        if (!bus.req[last]) begin
          if (|others) begin
            take     = 1'b1;
            take_idx = rr_pick(others, last);
          end else begin
            state_n = IDLE;
            gnt_n   = '0;
            valid_n = 1'b0;
            cnt_n   = '0;
          end
        end else if (cnt == CNT_MAX && !hold_lock) begin
          cnt_n = '0;
          if (|others) begin
            take     = 1'b1;
            take_idx = rr_pick(others, last);
          end
        end else if (cnt != CNT_MAX) begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase

    if (take) begin
      state_n = GRANT;
      gnt_n   = onehot(take_idx);
      sel_n   = take_idx;
      valid_n = 1'b1;
      cnt_n   = '0;
      last_n  = take_idx;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      last    <= SEL_W'(NUM_REQ - 1);
      gnt_r   <= '0;
      sel_r   <= '0;
      valid_r <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      last    <= last_n;
      gnt_r   <= gnt_n;
      sel_r   <= sel_n;
      valid_r <= valid_n;
    end
  end

  assign bus.gnt   = gnt_r;
  assign bus.s1    = sel_r[1];
  assign bus.s0    = sel_r[0];
  assign bus.valid = valid_r;

  for (genvar k = 0; k < DW; k++) begin : g_mux_bit
    mux_4_1 u_mux (
      .i0  (bus.din0[k]),
      .i1  (bus.din1[k]),
      .i2  (bus.din2[k]),
      .i3  (bus.din3[k]),
      .s1  (sel_r[1]),
      .s0  (sel_r[0]),
      .out (dout_w[k])
    );
  end

  assign bus.dout = dout_w;

endmodule

`default_nettype wire
